flash_cmd_seq: RTL and testbench

//  Sequences one complete SPI-flash transaction: chip select, opcode, 0-3 address bytes, 0..N data bytes, release.

---
 rtl/flash_cmd_seq.sv | 169 ++++++++++++++++
 tb/tb_flash_cmd_seq.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_seq.sv
// SPI-flash command sequencer: chip select, opcode, address, data, release.
// Drives the byte-wide serial_io shifter through SIO_WS / SIO_BUSY.
module flash_cmd_seq #(
  parameter int NW  = 9,
  parameter int CSS = 2,
  parameter int CSH = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CMD_GO,
  input  logic [7:0]    CMD_OP,
  input  logic [23:0]   CMD_ADDR,
  input  logic [1:0]    CMD_NADDR,
  input  logic [NW-1:0] CMD_NDATA,
  input  logic          CMD_RD,
  input  logic [7:0]    WD,
  input  logic          WD_VLD,
  output logic          WD_ACK,
  output logic [7:0]    RD,
  output logic          RD_STB,
  output logic          BUSY,
  output logic          DONE,
  output logic          FCS,
  output logic          SIO_WS,
  output logic [7:0]    SIO_WD,
  input  logic          SIO_BUSY,
  input  logic [7:0]    SIO_RD
);

  typedef enum logic [2:0] {
    IDLE, SETUP, OPC, ADR, DAT, WRW, WAIT, HOLD
  } state_t;

  localparam logic [7:0] CSS_L = 8'(CSS - 1);
  localparam logic [7:0] CSH_L = 8'(CSH - 1);

  state_t          st;
  logic [7:0]      op;
  logic [23:0]     addr;
  logic [1:0]      nadr;
  logic [NW-1:0]   ndat;
  logic            rdm;
  logic            rd_pend;
  logic [7:0]      cnt;

  // Remaining count n selects byte n-1 counted from the LSB end.
  function automatic logic [7:0] adr_byte(
    input logic [23:0] a,
    input logic [1:0]  n
  );
    logic [7:0] b;
    b = a[7:0];
    unique case (1'b1)
      (n == 2'd3): b = a[23:16];
      (n == 2'd2): b = a[15:8];
      default:     b = a[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      st      <= IDLE;
      op      <= '0;
      addr    <= '0;
      nadr    <= '0;
      ndat    <= '0;
      rdm     <= 1'b0;
      rd_pend <= 1'b0;
      cnt     <= '0;
      FCS     <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      SIO_WS  <= 1'b0;
      SIO_WD  <= '0;
      WD_ACK  <= 1'b0;
      RD_STB  <= 1'b0;
      RD      <= '0;
    end else begin
      SIO_WS <= 1'b0;
      WD_ACK <= 1'b0;
      RD_STB <= 1'b0;
      DONE   <= 1'b0;
      unique case (st)
        IDLE: begin
          if (CMD_GO) begin
            op      <= CMD_OP;
            addr    <= CMD_ADDR;
            nadr    <= CMD_NADDR;
            ndat    <= CMD_NDATA;
            rdm     <= CMD_RD;
            rd_pend <= 1'b0;
            cnt     <= '0;
            BUSY    <= 1'b1;
            FCS     <= 1'b0;
            st      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CSS_L) begin
            SIO_WS <= 1'b1;
            SIO_WD <= op;
            st     <= OPC;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        OPC, ADR, DAT: st <= WAIT;
        WAIT: begin
          if (!SIO_BUSY) begin
            rd_pend <= 1'b0;
            if (rd_pend) begin
              RD     <= SIO_RD;
              RD_STB <= 1'b1;
            end
            if (nadr != 2'd0) begin
              SIO_WS <= 1'b1;
              SIO_WD <= adr_byte(addr, nadr);
              nadr   <= nadr - 2'd1;
              st     <= ADR;
            end else if (ndat != '0) begin
              if (rdm) begin
                SIO_WS  <= 1'b1;
                SIO_WD  <= 8'h00;
                ndat    <= ndat - 1'b1;
                rd_pend <= 1'b1;
                st      <= DAT;
              end else if (WD_VLD) begin
                SIO_WS <= 1'b1;
                SIO_WD <= WD;
                WD_ACK <= 1'b1;
                ndat   <= ndat - 1'b1;
                st     <= DAT;
              end else begin
                st <= WRW;
              end
            end else begin
              FCS  <= 1'b1;
              cnt  <= '0;
              DONE <= (CSH == 1);
              st   <= HOLD;
            end
          end
        end
        // Host stall: chip select stays low, flash tolerates idle SCK.
        WRW: begin
          if (WD_VLD) begin
            SIO_WS <= 1'b1;
            SIO_WD <= WD;
            WD_ACK <= 1'b1;
            ndat   <= ndat - 1'b1;
            st     <= DAT;
          end
        end
        HOLD: begin
          if (cnt == CSH_L) begin
            BUSY <= 1'b0;
            st   <= IDLE;
          end else begin
            cnt  <= cnt + 8'd1;
            DONE <= ((cnt + 8'd1) == CSH_L);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Bench for flash_cmd_seq: serial_io/flash model, monitor and
// per-scenario tasks comparing a pushed expectation queue to observations.
module tb_flash_cmd_seq;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        CMD_GO;
  logic [7:0]  CMD_OP;
  logic [23:0] CMD_ADDR;
  logic [1:0]  CMD_NADDR;
  logic [8:0]  CMD_NDATA;
  logic        CMD_RD;
  logic [7:0]  WD;
  logic        WD_VLD;
  logic        WD_ACK;
  logic [7:0]  RD;
  logic        RD_STB;
  logic        BUSY;
  logic        DONE;
  logic        FCS;
  logic        SIO_WS;
  logic [7:0]  SIO_WD;
  logic        SIO_BUSY;
  logic [7:0]  SIO_RD;

  flash_cmd_seq dut (
    .CLK(CLK), .RSTN(RSTN), .CMD_GO(CMD_GO), .CMD_OP(CMD_OP),
    .CMD_ADDR(CMD_ADDR), .CMD_NADDR(CMD_NADDR), .CMD_NDATA(CMD_NDATA),
    .CMD_RD(CMD_RD), .WD(WD), .WD_VLD(WD_VLD), .WD_ACK(WD_ACK),
    .RD(RD), .RD_STB(RD_STB), .BUSY(BUSY), .DONE(DONE), .FCS(FCS),
    .SIO_WS(SIO_WS), .SIO_WD(SIO_WD), .SIO_BUSY(SIO_BUSY),
    .SIO_RD(SIO_RD)
  );

  always #4 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // serial_io + flash: busy 33 cycles after each strobe, 35-cycle byte period
  logic [7:0] resp [16];
  logic [5:0] bcnt;
  logic [3:0] bidx;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      SIO_BUSY <= 1'b0;
      SIO_RD   <= 8'h00;
      bcnt     <= '0;
      bidx     <= '0;
    end else begin
      if (FCS) bidx <= '0;
      else if (SIO_WS) bidx <= bidx + 4'd1;
      if (SIO_WS) begin
        SIO_BUSY <= 1'b1;
        bcnt     <= 6'd32;
        SIO_RD   <= resp[bidx];
      end else if (bcnt != 0) begin
        bcnt <= bcnt - 6'd1;
      end else begin
        SIO_BUSY <= 1'b0;
      end
    end
  end

  // monitor: cumulative counters, observed byte queues
  logic [7:0] obs_wd [$];
  logic [7:0] obs_rd [$];
  logic [7:0] exp_wd [$];
  logic [7:0] exp_rd [$];
  int ws_cnt = 0, ack_cnt = 0, stb_cnt = 0, dn_cnt = 0;
  int fl_cnt = 0, hc_cnt = 0, fr_cnt = 0, wv_cnt = 0;
  logic fcs_q = 1'b1;

  always @(negedge CLK) begin
    if (SIO_WS === 1'b1) begin
      ws_cnt++;
      obs_wd.push_back(SIO_WD);
      if (SIO_BUSY !== 1'b0 || FCS !== 1'b0) wv_cnt++;
    end
    if (WD_ACK === 1'b1) ack_cnt++;
    if (RD_STB === 1'b1) begin
      stb_cnt++;
      obs_rd.push_back(RD);
    end
    if (DONE === 1'b1) dn_cnt++;
    if (FCS === 1'b0) fl_cnt++;
    if (FCS === 1'b1 && BUSY === 1'b1) hc_cnt++;
    if (FCS === 1'b1 && fcs_q === 1'b0) fr_cnt++;
    fcs_q = FCS;
  end

  int ws0, ack0, stb0, dn0, fl0, hc0, fr0, wv0;
  logic go_busy, busy_after;
  logic [7:0] wdat [8];
  logic [7:0] e, o;

  task automatic snap();
    ws0 = ws_cnt; ack0 = ack_cnt; stb0 = stb_cnt; dn0 = dn_cnt;
    fl0 = fl_cnt; hc0 = hc_cnt; fr0 = fr_cnt; wv0 = wv_cnt;
  endtask

  // Issue one command from a negedge and follow it to DONE.
  task automatic run(input logic [7:0] op, input logic [23:0] ad,
                     input logic [1:0] na, input logic [8:0] nd,
                     input logic rdm, input int sidx, input int slen,
                     input bit spam);
    int idx, st;
    bit seen;
    idx = 0; st = 0; seen = 0;
    CMD_OP = op; CMD_ADDR = ad; CMD_NADDR = na;
    CMD_NDATA = nd; CMD_RD = rdm; CMD_GO = 1'b1;
    WD = wdat[0];
    WD_VLD = (nd != 0) && !rdm && (sidx != 0);
    @(negedge CLK);
    CMD_GO = 1'b0;
    go_busy = (BUSY === 1'b1) && (FCS === 1'b0);
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge CLK);
      if (WD_ACK === 1'b1) idx++;
      if (DONE === 1'b1) seen = 1;
      if (idx == sidx) st++;
      WD = (idx < 8) ? wdat[idx] : 8'h00;
      WD_VLD = (idx < int'(nd)) && !rdm && !(idx == sidx && st < slen);
      CMD_GO = spam && (seen || (c % 7 == 3));
    end
    @(negedge CLK);
    CMD_GO = 1'b0;
    WD_VLD = 1'b0;
    busy_after = BUSY;
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: DONE not seen, op %h", op);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; CMD_GO = 0; CMD_OP = 0; CMD_ADDR = 0; CMD_NADDR = 0;
    CMD_NDATA = 0; CMD_RD = 0; WD = 0; WD_VLD = 0;
    for (int i = 0; i < 16; i++) resp[i] = 8'hFF;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({FCS, BUSY, DONE, SIO_WS, WD_ACK, RD_STB} !== 6'b100000) begin
      miscompares++;
      $display("FAIL rst_ctl: got %b exp 100000",
               {FCS, BUSY, DONE, SIO_WS, WD_ACK, RD_STB});
    end
    vectors++;
    if (SIO_WD !== 8'h00) begin
      miscompares++; $display("FAIL rst_sio_wd: got %h exp 00", SIO_WD);
    end
    vectors++;
    if (RD !== 8'h00) begin
      miscompares++; $display("FAIL rst_rd: got %h exp 00", RD);
    end
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_opcode_only();
    snap();
    exp_wd.push_back(8'h06);
    run(8'h06, 24'h0, 2'd0, 9'd0, 1'b0, -1, 0, 0);
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = 8'hxx;
      if (obs_wd.size() > 0) o = obs_wd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL opc_wd: got %h exp %h", o, e);
      end
    end
    vectors++;
    if (obs_wd.size() != 0) begin
      miscompares++;
      $display("FAIL opc_extra: got %0d extra exp 0", obs_wd.size());
      obs_wd.delete();
    end
    vectors++;
    if (go_busy !== 1'b1) begin
      miscompares++; $display("FAIL opc_go_busy: got %b exp 1", go_busy);
    end
    vectors++;
    if (fl_cnt - fl0 != 37) begin
      miscompares++;
      $display("FAIL opc_fcs_low: got %0d exp 37", fl_cnt - fl0);
    end
    vectors++;
    if (hc_cnt - hc0 != 4) begin
      miscompares++;
      $display("FAIL opc_hold: got %0d exp 4", hc_cnt - hc0);
    end
    vectors++;
    if (dn_cnt - dn0 != 1) begin
      miscompares++;
      $display("FAIL opc_done: got %0d exp 1", dn_cnt - dn0);
    end
    vectors++;
    if (busy_after !== 1'b0) begin
      miscompares++; $display("FAIL opc_busy_end: got %b exp 0", busy_after);
    end
  endtask

  task automatic test_read_id();
    snap();
    resp[1] = 8'hEF; resp[2] = 8'h40; resp[3] = 8'h18;
    exp_wd.push_back(8'h9F);
    for (int i = 0; i < 3; i++) exp_wd.push_back(8'h00);
    exp_rd.push_back(8'hEF); exp_rd.push_back(8'h40);
    exp_rd.push_back(8'h18);
    run(8'h9F, 24'h0, 2'd0, 9'd3, 1'b1, -1, 0, 0);
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = 8'hxx;
      if (obs_wd.size() > 0) o = obs_wd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL rdid_wd: got %h exp %h", o, e);
      end
    end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = 8'hxx;
      if (obs_rd.size() > 0) o = obs_rd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL rdid_rd: got %h exp %h", o, e);
      end
    end
    vectors++;
    if (stb_cnt - stb0 != 3 || ws_cnt - ws0 != 4) begin
      miscompares++;
      $display("FAIL rdid_cnt: got stb %0d ws %0d exp 3 4",
               stb_cnt - stb0, ws_cnt - ws0);
    end
    obs_wd.delete(); obs_rd.delete();
  endtask

  task automatic test_page_program();
    snap();
    for (int i = 0; i < 4; i++) wdat[i] = 8'hA1 + 8'(i);
    exp_wd.push_back(8'h02); exp_wd.push_back(8'h12);
    exp_wd.push_back(8'h34); exp_wd.push_back(8'h56);
    for (int i = 0; i < 4; i++) exp_wd.push_back(wdat[i]);
    run(8'h02, 24'h123456, 2'd3, 9'd4, 1'b0, 2, 100, 0);
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = 8'hxx;
      if (obs_wd.size() > 0) o = obs_wd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL pp_wd: got %h exp %h", o, e);
      end
    end
    vectors++;
    if (ack_cnt - ack0 != 4) begin
      miscompares++;
      $display("FAIL pp_ack: got %0d exp 4", ack_cnt - ack0);
    end
    vectors++;
    if (fr_cnt - fr0 != 1) begin
      miscompares++;
      $display("FAIL pp_fcs_rise: got %0d exp 1", fr_cnt - fr0);
    end
    vectors++;
    if (fl_cnt - fl0 < 8 * 35 + 60) begin
      miscompares++;
      $display("FAIL pp_fcs_low: got %0d exp >= %0d", fl_cnt - fl0, 340);
    end
    obs_wd.delete();
  endtask

  task automatic test_read_1addr();
    snap();
    resp[2] = 8'h5A;
    exp_wd.push_back(8'h03); exp_wd.push_back(8'hEF);
    exp_wd.push_back(8'h00);
    exp_rd.push_back(8'h5A);
    run(8'h03, 24'hABCDEF, 2'd1, 9'd1, 1'b1, -1, 0, 0);
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = 8'hxx;
      if (obs_wd.size() > 0) o = obs_wd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL rd1_wd: got %h exp %h", o, e);
      end
    end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = 8'hxx;
      if (obs_rd.size() > 0) o = obs_rd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL rd1_rd: got %h exp %h", o, e);
      end
    end
    vectors++;
    if (obs_wd.size() != 0) begin
      miscompares++;
      $display("FAIL rd1_extra: got %0d extra exp 0", obs_wd.size());
    end
    obs_wd.delete(); obs_rd.delete();
  endtask

  task automatic test_go_ignored();
    snap();
    exp_wd.push_back(8'h06);
    run(8'h06, 24'h0, 2'd0, 9'd0, 1'b0, -1, 0, 1);
    repeat (60) @(negedge CLK);
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = 8'hxx;
      if (obs_wd.size() > 0) o = obs_wd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL goign_wd: got %h exp %h", o, e);
      end
    end
    vectors++;
    if (ws_cnt - ws0 != 1 || dn_cnt - dn0 != 1) begin
      miscompares++;
      $display("FAIL goign_cnt: got ws %0d done %0d exp 1 1",
               ws_cnt - ws0, dn_cnt - dn0);
    end
    vectors++;
    if (BUSY !== 1'b0 || FCS !== 1'b1) begin
      miscompares++;
      $display("FAIL goign_idle: got busy %b fcs %b exp 0 1", BUSY, FCS);
    end
    obs_wd.delete();
  endtask

  task automatic test_back_to_back();
    snap();
    wdat[0] = 8'hB1; wdat[1] = 8'hB2;
    exp_wd.push_back(8'h06);
    exp_wd.push_back(8'h02); exp_wd.push_back(8'h34);
    exp_wd.push_back(8'h56); exp_wd.push_back(8'hB1);
    exp_wd.push_back(8'hB2);
    run(8'h06, 24'h0, 2'd0, 9'd0, 1'b0, -1, 0, 0);
    run(8'h02, 24'h123456, 2'd2, 9'd2, 1'b0, -1, 0, 0);
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = 8'hxx;
      if (obs_wd.size() > 0) o = obs_wd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL b2b_wd: got %h exp %h", o, e);
      end
    end
    vectors++;
    if (dn_cnt - dn0 != 2 || ack_cnt - ack0 != 2) begin
      miscompares++;
      $display("FAIL b2b_cnt: got done %0d ack %0d exp 2 2",
               dn_cnt - dn0, ack_cnt - ack0);
    end
    vectors++;
    if (wv_cnt != 0) begin
      miscompares++;
      $display("FAIL ws_guard: got %0d bad strobes exp 0", wv_cnt);
    end
    obs_wd.delete();
  endtask

  task automatic test_reset_midcmd();
    int c;
    snap();
    CMD_OP = 8'h02; CMD_ADDR = 24'h123456; CMD_NADDR = 2'd3;
    CMD_NDATA = 9'd0; CMD_RD = 1'b0; CMD_GO = 1'b1;
    @(negedge CLK);
    CMD_GO = 1'b0;
    c = 0;
    while (c < 300 && ws_cnt - ws0 < 3) begin
      @(negedge CLK);
      c++;
    end
    vectors++;
    if (ws_cnt - ws0 < 3) begin
      miscompares++;
      $display("FAIL rstmid_reach: got %0d strobes exp 3", ws_cnt - ws0);
    end
    repeat (10) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    vectors++;
    if (FCS !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: got fcs %b busy %b exp 1 0", FCS, BUSY);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    obs_wd.delete(); obs_rd.delete();
    repeat (2) @(negedge CLK);
    snap();
    exp_wd.push_back(8'h06);
    run(8'h06, 24'h0, 2'd0, 9'd0, 1'b0, -1, 0, 0);
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = 8'hxx;
      if (obs_wd.size() > 0) o = obs_wd.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL rstmid_wd: got %h exp %h", o, e);
      end
    end
    vectors++;
    if (dn_cnt - dn0 != 1 || fl_cnt - fl0 != 37) begin
      miscompares++;
      $display("FAIL rstmid_cmd: got done %0d fcs_low %0d exp 1 37",
               dn_cnt - dn0, fl_cnt - fl0);
    end
  endtask

  initial begin
    test_reset();
    test_opcode_only();
    test_read_id();
    test_page_program();
    test_read_1addr();
    test_go_ignored();
    test_back_to_back();
    test_reset_midcmd();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
